// File: rtl/pc_fetch_unit.sv
// Program counter and fetch controller for the single-cycle RISC-V datapath.
// Drives the instruction ROM word address and gates the returned word by FSM state.
module pc_fetch_unit #(
    parameter int unsigned ADDR_BITS  = 5,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_INSTR = 32'h0000_0073,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    input  logic [31:0]          instr_in,
    output logic [ADDR_BITS-1:0] im_addr,
    output logic [31:0]          pc,
    output logic [31:0]          pc_plus4,
    output logic [31:0]          instr,
    output logic                 instr_valid,
    output logic                 halted,
    output logic                 fault,
    output logic [31:0]          retired
);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALT
    } state_t;

    // One past the last ROM byte address; 33 bits so the compare never wraps.
    localparam logic [32:0] ROM_BYTES = 33'd4 << ADDR_BITS;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] retired_q, retired_d;
    logic        fault_q, fault_d;

    logic [31:0] next_pc;
    logic        next_bad;
    logic [31:0] retired_inc;

    assign pc_plus4    = pc_q + 32'd4;
    assign next_pc     = redirect ? redirect_pc : pc_plus4;
    assign next_bad    = (next_pc[1:0] != 2'b00) || ({1'b0, next_pc} >= ROM_BYTES);
    assign retired_inc = (retired_q == '1) ? retired_q : retired_q + 32'd1;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        fault_d   = fault_q;
        unique case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (!stall) begin
                    retired_d = retired_inc;
                    if (instr_in == HALT_INSTR) begin
                        state_d = ST_HALT;
                    end else if (next_bad) begin
                        state_d = ST_HALT;
                        fault_d = 1'b1;
                    end else begin
                        pc_d = next_pc;
                    end
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_PC;
            retired_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            fault_q   <= fault_d;
        end
    end

    assign pc          = pc_q;
    assign im_addr     = pc_q[ADDR_BITS+1:2];
    assign instr_valid = (state_q == ST_RUN);
    assign halted      = (state_q == ST_HALT);
    assign instr       = instr_valid ? instr_in : NOP_INSTR;
    assign fault       = fault_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: stimulus pushes expected per-cycle state,
// a monitor pops and compares on the falling edge (or on demand for async reset).
module tb_pc_fetch_unit;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] ECAL = 32'h0000_0073;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr_in;
    logic [4:0]  im_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        instr_valid;
    logic        halted;
    logic        fault;
    logic [31:0] retired;

    logic [31:0] rom [32];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc;
        logic        v;
        logic        h;
        logic        f;
        logic [31:0] ret;
        logic [31:0] ins;
    } exp_t;

    exp_t sb[$];
    event chk_now;

    pc_fetch_unit #(
        .ADDR_BITS (5),
        .RESET_PC  (32'h0000_0000),
        .HALT_INSTR(ECAL),
        .NOP_INSTR (NOP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .instr_in   (instr_in),
        .im_addr    (im_addr),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .instr      (instr),
        .instr_valid(instr_valid),
        .halted     (halted),
        .fault      (fault),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    assign instr_in = rom[im_addr];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] e_pc, input logic e_v, input logic e_h,
                        input logic e_f, input logic [31:0] e_ret);
        exp_t e;
        logic [31:0] a;
        a     = e_pc;
        e.pc  = e_pc;
        e.v   = e_v;
        e.h   = e_h;
        e.f   = e_f;
        e.ret = e_ret;
        e.ins = e_v ? rom[a[6:2]] : NOP;
        sb.push_back(e);
    endtask

    // Drive one cycle's inputs, record the expected outputs for that cycle, advance.
    task automatic cyc(input logic st, input logic rd, input logic [31:0] rpc,
                       input logic [31:0] e_pc, input logic e_v, input logic e_h,
                       input logic e_f, input logic [31:0] e_ret);
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        push(e_pc, e_v, e_h, e_f, e_ret);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        logic [31:0] ea;
        forever begin
            @(negedge clk or chk_now);
            if (sb.size() > 0) begin
                e  = sb.pop_front();
                ea = e.pc + 32'd4;
                chk("pc",          pc,                  e.pc);
                chk("im_addr",     {27'd0, im_addr},    {27'd0, e.pc[6:2]});
                chk("pc_plus4",    pc_plus4,            ea);
                chk("instr_valid", {31'd0, instr_valid}, {31'd0, e.v});
                chk("halted",      {31'd0, halted},     {31'd0, e.h});
                chk("fault",       {31'd0, fault},      {31'd0, e.f});
                chk("retired",     retired,             e.ret);
                chk("instr",       instr,               e.ins);
            end
        end
    end

    initial begin : watchdog
        #20000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    task automatic reset_seq();
        rst_n = 1'b0;
        cyc(0, 0, 0, 32'h0, 0, 0, 0, 0);
        rst_n = 1'b1;
        cyc(0, 0, 0, 32'h0, 0, 0, 0, 0);
    endtask

    initial begin : stim
        for (int i = 0; i < 32; i++) rom[i] = NOP;
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        @(posedge clk);
        #1;

        // sequential fetch, redirect, stall with ignored redirect, misaligned redirect
        reset_seq();
        cyc(0, 0, 0,        32'h00, 1, 0, 0, 0);
        cyc(0, 0, 0,        32'h04, 1, 0, 0, 1);
        cyc(0, 1, 32'h40,   32'h08, 1, 0, 0, 2);
        cyc(0, 0, 0,        32'h40, 1, 0, 0, 3);
        cyc(0, 1, 32'h10,   32'h44, 1, 0, 0, 4);
        cyc(1, 0, 0,        32'h10, 1, 0, 0, 5);
        cyc(1, 1, 32'h60,   32'h10, 1, 0, 0, 5);
        cyc(1, 0, 0,        32'h10, 1, 0, 0, 5);
        cyc(0, 0, 0,        32'h10, 1, 0, 0, 5);
        cyc(0, 1, 32'h06,   32'h14, 1, 0, 0, 6);
        cyc(0, 1, 32'h20,   32'h14, 0, 1, 1, 7);
        cyc(0, 0, 0,        32'h14, 0, 1, 1, 7);
        cyc(0, 0, 0,        32'h14, 0, 1, 1, 7);

        // last ROM word is legal, falling through past it faults
        reset_seq();
        cyc(0, 1, 32'h78,   32'h00, 1, 0, 0, 0);
        cyc(0, 0, 0,        32'h78, 1, 0, 0, 1);
        cyc(0, 0, 0,        32'h7C, 1, 0, 0, 2);
        cyc(0, 0, 0,        32'h7C, 0, 1, 1, 3);
        cyc(0, 0, 0,        32'h7C, 0, 1, 1, 3);

        // wrap-around redirect target is out of range
        reset_seq();
        cyc(0, 1, 32'hFFFF_FFFC, 32'h00, 1, 0, 0, 0);
        cyc(0, 0, 0,        32'h00, 0, 1, 1, 1);

        // ECALL halts without fault, outranking a pending redirect
        rom[3] = ECAL;
        reset_seq();
        cyc(0, 0, 0,        32'h00, 1, 0, 0, 0);
        cyc(0, 0, 0,        32'h04, 1, 0, 0, 1);
        cyc(0, 0, 0,        32'h08, 1, 0, 0, 2);
        cyc(0, 1, 32'h06,   32'h0C, 1, 0, 0, 3);
        for (int i = 0; i < 10; i++) cyc(0, (i % 2) == 0, 32'h20, 32'h0C, 0, 1, 0, 4);
        rom[3] = NOP;

        // asynchronous reset between clock edges
        reset_seq();
        cyc(0, 1, 32'h1C,   32'h00, 1, 0, 0, 0);
        cyc(0, 0, 0,        32'h1C, 1, 0, 0, 1);
        stall    = 1'b0;
        redirect = 1'b0;
        push(32'h20, 1, 0, 0, 2);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        push(32'h00, 0, 0, 0, 0);
        ->chk_now;
        @(posedge clk);
        #1;
        cyc(0, 0, 0,        32'h00, 0, 0, 0, 0);
        rst_n = 1'b1;
        cyc(0, 0, 0,        32'h00, 0, 0, 0, 0);
        cyc(0, 0, 0,        32'h00, 1, 0, 0, 0);
        cyc(0, 0, 0,        32'h04, 1, 0, 0, 1);

        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got=%0d expected=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
